// File: rtl/dram_cache_pkg.sv
// Shared definitions for the DRAM-cache request path.
// Both the index extractor (FIFO writer) and the index request reader (FIFO
// reader) import this package, so the 128-bit request entry layout lives in
// exactly one place.
// Contents: entry bit positions, the packed entry struct, the default cache
// geometry and the output-buffer state type.
package dram_cache_pkg;

  localparam int ENTRY_WIDTH    = 128;
  localparam int ENTRY_ADDR_LSB = 0;
  localparam int ENTRY_ID_LSB   = 32;
  localparam int ENTRY_WR_BIT   = 64;
  localparam int ENTRY_IDX_LSB  = 65;
  localparam int ENTRY_RSVD_LSB = 69;

  // 16 sets, 64-byte lines
  localparam int DEFAULT_INDEX_WIDTH  = 4;
  localparam int DEFAULT_OFFSET_WIDTH = 6;

  // Field widths are derived from the bit positions above so the struct and
  // the constants cannot drift apart. Packed structs list the MSB field first.
  typedef struct packed {
    logic [ENTRY_WIDTH-ENTRY_RSVD_LSB-1:0]    rsvd;
    logic [ENTRY_RSVD_LSB-ENTRY_IDX_LSB-1:0]  index;
    logic                                     is_write;
    logic [ENTRY_WR_BIT-ENTRY_ID_LSB-1:0]     id;
    logic [ENTRY_ID_LSB-ENTRY_ADDR_LSB-1:0]   addr;
  } req_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/req_skid_buffer.sv
// Two-entry valid/ready buffer. The head register drives the output; a
// second register absorbs one extra word so the upstream can keep issuing
// while the consumer stalls.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   in_valid    write in_data at the tail this cycle
//   in_data     payload to store
//   out_valid   head holds a word
//   out_ready   consumer accepts the head this cycle
//   out_data    head word (held stable until accepted)
//   level       number of stored words (0..2)
// The writer must never push while FULL unless the head is popped in the same
// cycle; the reader's credit counter guarantees this.
module req_skid_buffer
  import dram_cache_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  buf_state_t       state, state_next;
  logic [WIDTH-1:0] head_q, tail_q;
  logic             pop;

  assign pop      = out_valid && out_ready;
  assign out_data = head_q;

  // Occupancy state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next occupancy plus the status outputs decoded from it
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    level      = 2'd0;
    case (state)
      BUF_EMPTY: begin
        if (in_valid) state_next = BUF_ONE;
      end
      BUF_ONE: begin
        out_valid = 1'b1;
        level     = 2'd1;
        if (in_valid && !pop)      state_next = BUF_FULL;
        else if (pop && !in_valid) state_next = BUF_EMPTY;
      end
      BUF_FULL: begin
        out_valid = 1'b1;
        level     = 2'd2;
        if (pop && !in_valid) state_next = BUF_ONE;
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  // Data movement: a push lands in the head when the head is free (or being
  // vacated with nothing behind it), otherwise in the tail
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (in_valid) head_q <= in_data;
        end
        BUF_ONE: begin
          if (in_valid && pop) head_q <= in_data;
          else if (in_valid)   tail_q <= in_data;
        end
        BUF_FULL: begin
          if (pop) begin
            head_q <= tail_q;
            if (in_valid) tail_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/index_request_reader.sv
// Drains the request FIFO filled by the index extractor, decodes each 128-bit
// entry and presents it on a valid/ready port toward the tag-lookup stage.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   fifo_empty_i           request FIFO empty
//   fifo_rd_en_o           pop strobe; data returns the following cycle
//   fifo_rdata_i           popped entry
//   req_valid_o/ready_i    request handshake
//   req_id_o, req_addr_o   AXI id and full address
//   req_write_o            1 = write, 0 = read
//   req_index_o, req_tag_o set index and tag, both sliced from the address
//   err_o                  sticky: some entry was malformed since reset
//   rd_count_o/wr_count_o  dispatched read/write counts (wrapping)
module index_request_reader
  import dram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 32,
  parameter int INDEX_WIDTH  = DEFAULT_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = DEFAULT_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  input  logic [ENTRY_WIDTH-1:0] fifo_rdata_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [ID_WIDTH-1:0]    req_id_o,
  output logic [ADDR_WIDTH-1:0]  req_addr_o,
  output logic                   req_write_o,
  output logic [INDEX_WIDTH-1:0] req_index_o,
  output logic [TAG_WIDTH-1:0]   req_tag_o,
  output logic                   err_o,
  output logic [15:0]            rd_count_o,
  output logic [15:0]            wr_count_o
);

  // Index and tag are re-derived from the address at the output, so only
  // direction, id and address travel through the buffer.
  localparam int PAYLOAD_WIDTH = 1 + ID_WIDTH + ADDR_WIDTH;

  req_entry_t               entry;
  logic [ADDR_WIDTH-1:0]    entry_addr;
  logic [INDEX_WIDTH-1:0]   addr_index;
  logic                     malformed;
  logic                     pop_inflight;
  logic                     handshake;
  logic [1:0]               buf_level;
  logic [1:0]               occ;
  logic [PAYLOAD_WIDTH-1:0] in_payload;
  logic [PAYLOAD_WIDTH-1:0] head_payload;

  assign entry      = req_entry_t'(fifo_rdata_i);
  assign entry_addr = entry.addr[ADDR_WIDTH-1:0];
  assign addr_index = entry_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign malformed  = (|entry.rsvd) || (INDEX_WIDTH'(entry.index) != addr_index);
  assign in_payload = {entry.is_write, entry.id[ID_WIDTH-1:0], entry_addr};

  assign handshake = req_valid_o && req_ready_i;

  // Credit = buffered words + the pop whose data arrives next cycle. A
  // handshake frees a slot in the same cycle, which is what keeps the
  // stream at one request per cycle. Reset blocks pops because the FIFO
  // owner is being reset alongside us.
  assign occ          = buf_level + {1'b0, pop_inflight};
  assign fifo_rd_en_o = rst_n && !fifo_empty_i && ((occ < 2'd2) || handshake);

  // A pop this cycle means fifo_rdata_i is valid (and captured) next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pop_inflight <= 1'b0;
    end else begin
      pop_inflight <= fifo_rd_en_o;
    end
  end

  // Sticky malformed-entry flag, raised at capture time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (pop_inflight && malformed) begin
      err_o <= 1'b1;
    end
  end

  // Dispatch counters, free-running 16-bit wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (handshake) begin
      if (req_write_o) wr_count_o <= wr_count_o + 16'd1;
      else             rd_count_o <= rd_count_o + 16'd1;
    end
  end

  req_skid_buffer #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pop_inflight),
    .in_data   (in_payload),
    .out_valid (req_valid_o),
    .out_ready (req_ready_i),
    .out_data  (head_payload),
    .level     (buf_level)
  );

  assign {req_write_o, req_id_o, req_addr_o} = head_payload;
  assign req_index_o = req_addr_o[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag_o   = req_addr_o[ADDR_WIDTH-1 -: TAG_WIDTH];

endmodule

// File: tb/tb_index_request_reader.sv
// Testbench for index_request_reader. A FIFO model feeds the DUT; every entry
// pushed also pushes its expected request (computed from address arithmetic)
// into a scoreboard that a separate monitor drains on each handshake.
module tb_index_request_reader;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  index;
    logic [21:0] tag;
    logic        bad;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty_i;
  logic         fifo_rd_en_o;
  logic [127:0] fifo_rdata_i = '0;
  logic         req_valid_o;
  logic         req_ready_i;
  logic [31:0]  req_id_o;
  logic [31:0]  req_addr_o;
  logic         req_write_o;
  logic [3:0]   req_index_o;
  logic [21:0]  req_tag_o;
  logic         err_o;
  logic [15:0]  rd_count_o;
  logic [15:0]  wr_count_o;

  int checks = 0;
  int errors = 0;

  logic [127:0] fifo_mem [DEPTH];
  int unsigned  wr_ptr = 0;
  int unsigned  rd_ptr = 0;
  int unsigned  pop_count = 0;

  exp_t         exp_mem [DEPTH];
  int unsigned  exp_wr = 0;
  int unsigned  exp_rd = 0;
  logic [15:0]  m_rd = '0;
  logic [15:0]  m_wr = '0;
  logic         m_err = 1'b0;

  index_request_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_rdata_i (fifo_rdata_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_id_o     (req_id_o),
    .req_addr_o   (req_addr_o),
    .req_write_o  (req_write_o),
    .req_index_o  (req_index_o),
    .req_tag_o    (req_tag_o),
    .err_o        (err_o),
    .rd_count_o   (rd_count_o),
    .wr_count_o   (wr_count_o)
  );

  always #5 clk = ~clk;

  // Request FIFO model: one-cycle read latency, flushed by the shared reset
  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en_o) begin
      pop_count <= pop_count + 1;
      if (!fifo_empty_i) begin
        fifo_rdata_i <= fifo_mem[rd_ptr % DEPTH];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: fields come straight from the layout, index and tag by
  // dividing the address by the line size and set count
  function automatic exp_t model(input logic [127:0] e);
    exp_t        r;
    int unsigned a;
    a       = e[31:0];
    r.addr  = a;
    r.id    = e[63:32];
    r.wr    = e[64];
    r.index = 4'((a / 64) % 16);
    r.tag   = 22'(a / 1024);
    r.bad   = ((e >> 69) != 128'd0) || (((e >> 65) & 128'hF) != 128'(r.index));
    return r;
  endfunction

  function automatic logic [127:0] make_entry(input logic [31:0] addr, input logic [31:0] id,
                                              input logic wr, input logic [3:0] idx);
    logic [127:0] e;
    e = '0;
    e[31:0]  = addr;
    e[63:32] = id;
    e[64]    = wr;
    e[68:65] = idx;
    return e;
  endfunction

  function automatic logic [127:0] good_entry(input logic [31:0] addr, input logic [31:0] id, input logic wr);
    return make_entry(addr, id, wr, 4'((addr / 64) % 16));
  endfunction

  function automatic logic [127:0] random_entry();
    logic [127:0] e;
    logic [31:0]  a;
    a = $urandom;
    e = good_entry(a, $urandom, 1'($urandom_range(0, 1)));
    if ($urandom_range(0, 15) == 0) e[68:65] = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 15) == 0) e[69 + $urandom_range(0, 58)] = 1'b1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one entry into the FIFO model and its expected request into the
  // scoreboard, waiting (bounded) for room first
  task automatic applyStimulus(input logic [127:0] e);
    int n;
    n = 0;
    while ((exp_wr - exp_rd) >= DEPTH - 8 && n < 1000) begin
      step();
      n++;
    end
    checkOutput("fifo_space", 64'((exp_wr - exp_rd) < DEPTH - 8), 64'd1);
    fifo_mem[wr_ptr % DEPTH] = e;
    exp_mem[exp_wr % DEPTH]  = model(e);
    wr_ptr++;
    exp_wr++;
  endtask

  task automatic drain();
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk);
      done = (exp_rd == exp_wr) && fifo_empty_i && !req_valid_o;
      n++;
    end
    checkOutput("drain_done", 64'(done), 64'd1);
    checkOutput("rd_count_model", 64'(rd_count_o), 64'(m_rd));
    checkOutput("wr_count_model", 64'(wr_count_o), 64'(m_wr));
    checkOutput("err_model", 64'(err_o), 64'(m_err));
    step();
  endtask

  // Monitor: pops the scoreboard on each handshake and checks that a stalled
  // request holds its value until accepted
  initial begin : monitor
    exp_t        cur;
    logic        hold = 1'b0;
    logic [90:0] hold_snap = '0;
    logic [90:0] snap;
    forever begin
      @(negedge clk);
      snap = {req_write_o, req_id_o, req_addr_o, req_index_o, req_tag_o};
      if (!rst_n) begin
        exp_rd = exp_wr;
        m_rd   = '0;
        m_wr   = '0;
        m_err  = 1'b0;
        hold   = 1'b0;
      end else begin
        if (hold) begin
          checkOutput("hold_valid", 64'(req_valid_o), 64'd1);
          checkOutput("hold_stable", 64'(snap == hold_snap), 64'd1);
        end
        if (req_valid_o && req_ready_i) begin
          checkOutput("pending_expected", 64'(exp_rd != exp_wr), 64'd1);
          if (exp_rd != exp_wr) begin
            cur = exp_mem[exp_rd % DEPTH];
            exp_rd++;
            checkOutput("req_id", 64'(req_id_o), 64'(cur.id));
            checkOutput("req_addr", 64'(req_addr_o), 64'(cur.addr));
            checkOutput("req_write", 64'(req_write_o), 64'(cur.wr));
            checkOutput("req_index", 64'(req_index_o), 64'(cur.index));
            checkOutput("req_tag", 64'(req_tag_o), 64'(cur.tag));
            if (cur.bad) begin
              m_err = 1'b1;
              checkOutput("err_on_bad", 64'(err_o), 64'd1);
            end
            if (cur.wr) m_wr = m_wr + 16'd1;
            else        m_rd = m_rd + 16'd1;
          end
        end
        hold      = req_valid_o && !req_ready_i;
        hold_snap = snap;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int unsigned  base;
    int           n;
    logic [127:0] e;

    rst_n       = 1'b0;
    req_ready_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checkOutput("rst_valid", 64'(req_valid_o), 64'd0);
    checkOutput("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    checkOutput("rst_id", 64'(req_id_o), 64'd0);
    checkOutput("rst_addr", 64'(req_addr_o), 64'd0);
    checkOutput("rst_write", 64'(req_write_o), 64'd0);
    checkOutput("rst_index", 64'(req_index_o), 64'd0);
    checkOutput("rst_tag", 64'(req_tag_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);
    checkOutput("rst_rd_count", 64'(rd_count_o), 64'd0);
    checkOutput("rst_wr_count", 64'(wr_count_o), 64'd0);
    step();
    rst_n = 1'b1;

    $display("[TB] single read");
    req_ready_i = 1'b1;
    base = pop_count;
    applyStimulus(make_entry(32'h0000_00C4, 32'd3, 1'b0, 4'd3));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_rd_en_o && n < 20);
    checkOutput("single_pop_seen", 64'(fifo_rd_en_o), 64'd1);
    @(negedge clk);
    checkOutput("latency_n1_valid", 64'(req_valid_o), 64'd0);
    @(negedge clk);
    checkOutput("latency_n2_valid", 64'(req_valid_o), 64'd1);
    checkOutput("single_id", 64'(req_id_o), 64'd3);
    checkOutput("single_index", 64'(req_index_o), 64'd3);
    checkOutput("single_tag", 64'(req_tag_o), 64'd0);
    checkOutput("single_write", 64'(req_write_o), 64'd0);
    step();
    drain();
    checkOutput("single_pops", 64'(pop_count - base), 64'd1);
    checkOutput("single_rd_count", 64'(rd_count_o), 64'd1);

    $display("[TB] streaming");
    base = pop_count;
    for (int i = 0; i < 8; i++) applyStimulus(good_entry($urandom, $urandom, 1'(i % 2)));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_valid_o && n < 20);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_b2b", 64'(req_valid_o && req_ready_i), 64'd1);
      @(negedge clk);
    end
    step();
    drain();
    checkOutput("stream_pops", 64'(pop_count - base), 64'd8);
    checkOutput("stream_rd_count", 64'(rd_count_o), 64'd5);
    checkOutput("stream_wr_count", 64'(wr_count_o), 64'd4);

    $display("[TB] backpressure");
    req_ready_i = 1'b0;
    base = pop_count;
    for (int i = 0; i < 5; i++) applyStimulus(good_entry($urandom, $urandom, 1'($urandom_range(0, 1))));
    repeat (10) @(negedge clk);
    checkOutput("bp_pops", 64'(pop_count - base), 64'd2);
    checkOutput("bp_rd_en_low", 64'(fifo_rd_en_o), 64'd0);
    checkOutput("bp_valid", 64'(req_valid_o), 64'd1);
    step();
    req_ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_resume", 64'(fifo_rd_en_o), 64'd1);
    step();
    drain();
    checkOutput("bp_total_pops", 64'(pop_count - base), 64'd5);

    $display("[TB] malformed entries");
    checkOutput("err_before_bad", 64'(err_o), 64'd0);
    applyStimulus(make_entry(32'h0000_0040, 32'd7, 1'b0, 4'd5));
    e = good_entry(32'h0000_0A80, 32'd8, 1'b1);
    e[100] = 1'b1;
    applyStimulus(e);
    drain();
    checkOutput("err_after_bad", 64'(err_o), 64'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      req_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) applyStimulus(random_entry());
      step();
    end
    req_ready_i = 1'b1;
    drain();
    checkOutput("err_sticky", 64'(err_o), 64'd1);

    $display("[TB] reset mid-stream");
    req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(good_entry($urandom, $urandom, 1'($urandom_range(0, 1))));
    repeat (6) @(negedge clk);
    step();
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    rst_n       = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstmid_valid", 64'(req_valid_o), 64'd0);
      checkOutput("rstmid_rd_en", 64'(fifo_rd_en_o), 64'd0);
    end
    checkOutput("rstmid_id", 64'(req_id_o), 64'd0);
    checkOutput("rstmid_addr", 64'(req_addr_o), 64'd0);
    checkOutput("rstmid_err", 64'(err_o), 64'd0);
    checkOutput("rstmid_rd_count", 64'(rd_count_o), 64'd0);
    checkOutput("rstmid_wr_count", 64'(wr_count_o), 64'd0);
    step();
    req_ready_i = 1'b1;
    applyStimulus(good_entry(32'h1234_5678, 32'hA5, 1'b0));
    drain();
    checkOutput("rstmid_first_rd", 64'(rd_count_o), 64'd1);

    $display("[TB] counter wrap");
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(good_entry($urandom, $urandom, 1'b1));
      step();
    end
    drain();
    checkOutput("wrap_wr_max", 64'(wr_count_o), 64'hFFFF);
    applyStimulus(good_entry($urandom, $urandom, 1'b1));
    drain();
    checkOutput("wrap_wr_zero", 64'(wr_count_o), 64'd0);
    checkOutput("wrap_rd_kept", 64'(rd_count_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
